series_func_engine: RTL

- Parametrised successor to the four-function series evaluator.
- Evaluates an N-term polynomial/series selected by `func` at a fractional input `x`, using Horner's method, one term per clock.
- Coefficients come from an external combinational coefficient table through an `addr`/data port. Signed fixed-point result with configurable integer width and an overflow flag.
- Sits between the control sequencer and a per-function coefficient ROM.

---
 rtl/series_func_engine.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/series_func_engine.sv
// series_func_engine: Horner-method series evaluator, one coefficient per clock.
// Coefficients are read from an external combinational table via addr/tableData.
// Result is a saturated signed fixed-point value with I_WIDTH integer bits and
// F_WIDTH fraction bits.
//
// Build option:
//   SERIES_FUNC_ROUND_EN  defined   -> product is rounded half up before the add
//                         undefined -> product is truncated (floor)
//
// state | meaning
// IDLE  | waiting for start, addr=0
// LOAD  | reading c[N-1] into the accumulator (completes here when N=1)
// ITER  | one Horner step per cycle, k counts down to 0
// Completion is a registered update on the last LOAD/ITER edge, so the
// design returns straight to IDLE with done pulsing for one cycle.
module series_func_engine #(
  parameter int F_WIDTH      = 8,
  parameter int I_WIDTH      = 2,
  parameter int NUM_OF_TERMS = 8,
  parameter int CNT_WIDTH    = 4,
  parameter int FUNC_WIDTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [FUNC_WIDTH-1:0]         func,
  input  logic [F_WIDTH-1:0]            x,
  output logic                          busy,
  output logic                          done,
  output logic                          ovf,
  output logic [FUNC_WIDTH+CNT_WIDTH-1:0] addr,
  input  logic [I_WIDTH+F_WIDTH-1:0]    tableData,
  output logic [I_WIDTH-1:0]            resultIPart,
  output logic [F_WIDTH-1:0]            resultFPart
);

  localparam int W   = I_WIDTH + F_WIDTH;
  localparam int P_W = W + F_WIDTH + 1;
  localparam int S_W = P_W + 1;

  localparam logic [CNT_WIDTH-1:0] K_LAST  = CNT_WIDTH'(NUM_OF_TERMS - 1);
  localparam logic [CNT_WIDTH-1:0] K_START =
    CNT_WIDTH'((NUM_OF_TERMS > 1) ? (NUM_OF_TERMS - 2) : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ITER = 2'd2
  } state_t;

  state_t                  state_q;
  logic [FUNC_WIDTH-1:0]   func_q;
  logic [F_WIDTH-1:0]      x_q;
  logic [CNT_WIDTH-1:0]    k_q;
  logic [W-1:0]            acc_q;
  logic                    ovf_acc_q;
  logic [W-1:0]            result_q;
  logic                    ovf_q;
  logic                    busy_q;
  logic                    done_q;

  // Horner step datapath: widths are chosen so nothing is lost before saturation.
  logic signed [P_W-1:0]   acc_ext;
  logic signed [P_W-1:0]   x_ext;
  logic signed [P_W-1:0]   prod;
  logic signed [P_W-1:0]   prod_adj;
  logic signed [P_W-1:0]   term;
  logic signed [S_W-1:0]   sum;
  logic [S_W-W:0]          sum_hi;
  logic                    sat;
  logic [W-1:0]            acc_d;

  assign acc_ext = {{(P_W-W){acc_q[W-1]}}, acc_q};
  assign x_ext   = {{(P_W-F_WIDTH){1'b0}}, x_q};
  assign prod    = acc_ext * x_ext;

`ifdef SERIES_FUNC_ROUND_EN
  localparam logic signed [P_W-1:0] ROUND_HALF = P_W'(1) << (F_WIDTH - 1);
  assign prod_adj = prod + ROUND_HALF;
`else
  assign prod_adj = prod;
`endif

  assign term   = prod_adj >>> F_WIDTH;
  assign sum    = {term[P_W-1], term} + {{(S_W-W){tableData[W-1]}}, tableData};

  // In range only when every bit from the W-bit sign position upward agrees.
  assign sum_hi = sum[S_W-1:W-1];
  assign sat    = !((&sum_hi) || (~|sum_hi));
  assign acc_d  = !sat               ? sum[W-1:0] :
                  sum[S_W-1]         ? {1'b1, {(W-1){1'b0}}} :
                                       {1'b0, {(W-1){1'b1}}};

  // Coefficient address follows the registered state and term index.
  always_comb begin
    addr = '0;
    case (state_q)
      S_LOAD:  addr = {func_q, K_LAST};
      S_ITER:  addr = {func_q, k_q};
      default: addr = '0;
    endcase
  end

  // Sequencer: accept start, load the leading coefficient, iterate, complete.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      func_q    <= '0;
      x_q       <= '0;
      k_q       <= '0;
      acc_q     <= '0;
      ovf_acc_q <= 1'b0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            func_q    <= func;
            x_q       <= x;
            ovf_acc_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (NUM_OF_TERMS == 1) begin
            result_q <= tableData;
            ovf_q    <= ovf_acc_q;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end else begin
            acc_q   <= tableData;
            k_q     <= K_START;
            state_q <= S_ITER;
          end
        end
        S_ITER: begin
          acc_q     <= acc_d;
          ovf_acc_q <= ovf_acc_q | sat;
          if (k_q == '0) begin
            result_q <= acc_d;
            ovf_q    <= ovf_acc_q | sat;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end else begin
            k_q <= k_q - CNT_WIDTH'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign ovf         = ovf_q;
  assign resultIPart = result_q[W-1:F_WIDTH];
  assign resultFPart = result_q[F_WIDTH-1:0];

endmodule
